// File: rtl/urp_pcie_pkg.sv
// urp_pcie_pkg
//   Shared CRC32 definitions used by the transmit-side encoder and the
//   receive-side checker. Both sides use the same polynomial, seed and bit
//   ordering, so an encoder->checker loop always compares clean.
//   CRC convention: non-reflected, seed all-ones, data consumed MSB first,
//   no final inversion.
package urp_pcie_pkg;

  localparam int CRC_WIDTH = 32;

  typedef logic [CRC_WIDTH-1:0] crc32_t;

  localparam crc32_t CRC32_POLY = 32'h04C1_1DB7;
  localparam crc32_t CRC32_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/urp_pcie_crc32_gen.sv
// urp_pcie_crc32_gen
//   Purely combinational CRC32 over one full data word.
//   Ports:
//     data  in  DATA_WIDTH  word to protect; bit DATA_WIDTH-1 is shifted in first
//     crc   out 32          CRC32 of data, starting from CRC32_INIT
module urp_pcie_crc32_gen #(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [31:0]           crc
);
  import urp_pcie_pkg::*;

  // chain[n] is the CRC register after the first n data bits have been shifted in.
  crc32_t chain [DATA_WIDTH+1];

  assign chain[0] = CRC32_INIT;

  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    logic fb;
    assign fb            = chain[gi][CRC_WIDTH-1] ^ data[DATA_WIDTH-1-gi];
    assign chain[gi+1]   = {chain[gi][CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
  end

  assign crc = chain[DATA_WIDTH];

endmodule

// File: rtl/urp_pcie_crc32_chk.sv
// urp_pcie_crc32_chk
//   Receive-side CRC32 checker. Recomputes the CRC of each incoming beat,
//   compares it with the attached checksum and forwards the beat with an
//   error flag through a two-stage elastic valid/ready pipeline.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     valid_i/ready_o   input handshake; data_i + checksum_i travel together
//     valid_o/ready_i   output handshake; data_o + crc_err_o travel together
//     nak_o             one-cycle pulse for every failing beat
//     err_cnt_o         saturating count of failing beats
//     clr_cnt_i         synchronous clear of err_cnt_o (clear wins before count)
//   DROP_BAD=1 swallows failing beats instead of forwarding them.
//   Only CRC_WIDTH=32 is supported.
module urp_pcie_crc32_chk #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DROP_BAD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CRC_WIDTH-1:0]  checksum_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  crc_err_o,
  output logic                  nak_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  input  logic                  clr_cnt_i
);
  import urp_pcie_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Stage 1: captured beat plus its recomputed CRC
  logic                  s1_vld_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic [CRC_WIDTH-1:0]  s1_rx_reg;
  crc32_t                s1_calc_reg;

  // Stage 2: output register
  logic                  s2_vld_reg;
  logic [DATA_WIDTH-1:0] s2_data_reg;
  logic                  s2_err_reg;

  logic                  nak_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [CNT_WIDTH-1:0]  cnt_next;

  crc32_t calc_crc;
  logic   s2_take;
  logic   s1_adv;
  logic   s1_err;
  logic   s2_load;
  logic   in_xfer;

  urp_pcie_crc32_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gen (
    .data (data_i),
    .crc  (calc_crc)
  );

  assign s2_take = !s2_vld_reg || ready_i;
  assign s1_adv  = s1_vld_reg && s2_take;
  // rst_n gating keeps ready_o low while reset is held; state alone would
  // already report "empty" during the reset cycle.
  assign ready_o = rst_n && (!s1_vld_reg || s1_adv);
  assign in_xfer = valid_i && ready_o;
  assign s1_err  = (s1_calc_reg != s1_rx_reg);
  assign s2_load = s1_adv && !((DROP_BAD != 0) && s1_err);

  // Clear first, then count, so a clear coinciding with an error yields 1.
  always_comb begin
    cnt_next = clr_cnt_i ? '0 : cnt_reg;
    if (s1_adv && s1_err && (cnt_next != CNT_MAX)) begin
      cnt_next = cnt_next + CNT_WIDTH'(1);
    end
  end

  // Control state: reset to a known empty pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
      s2_err_reg <= 1'b0;
      nak_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if (in_xfer) begin
        s1_vld_reg <= 1'b1;
      end else if (s1_adv) begin
        s1_vld_reg <= 1'b0;
      end

      if (s2_load) begin
        s2_vld_reg <= 1'b1;
        s2_err_reg <= s1_err;
      end else if (ready_i) begin
        // Output taken and nothing (or only a dropped beat) replaces it.
        s2_vld_reg <= 1'b0;
      end

      nak_reg <= s1_adv && s1_err;
      cnt_reg <= cnt_next;
    end
  end

  // Datapath registers: contents are don't-care while the valid bits are low.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_data_reg <= data_i;
      s1_rx_reg   <= checksum_i;
      s1_calc_reg <= calc_crc;
    end
    if (s2_load) begin
      s2_data_reg <= s1_data_reg;
    end
  end

  assign valid_o   = s2_vld_reg;
  assign data_o    = s2_data_reg;
  assign crc_err_o = s2_err_reg;
  assign nak_o     = nak_reg;
  assign err_cnt_o = cnt_reg;

endmodule

// File: tb/tb_urp_pcie_crc32_chk.sv
// tb_urp_pcie_crc32_chk
//   Three checker instances: index 0 forwards bad beats (16-bit counter),
//   index 1 drops bad beats, index 2 has a 4-bit counter for saturation.
//   A byte-table CRC32 model and an ordered scoreboard of expected beats
//   predict every output beat.
module tb_urp_pcie_crc32_chk;

  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          valid_i   [3];
  logic          ready_o   [3];
  logic [DW-1:0] data_i    [3];
  logic [31:0]   cks_i     [3];
  logic          valid_o   [3];
  logic          ready_i   [3];
  logic [DW-1:0] data_o    [3];
  logic          crc_err_o [3];
  logic          nak_o     [3];
  logic          clr_i     [3];
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;
  logic [3:0]    cnt2;

  urp_pcie_crc32_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .DROP_BAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .data_i(data_i[0]), .checksum_i(cks_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .data_o(data_o[0]), .crc_err_o(crc_err_o[0]), .nak_o(nak_o[0]), .err_cnt_o(cnt0),
    .clr_cnt_i(clr_i[0]));

  urp_pcie_crc32_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .DROP_BAD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .data_i(data_i[1]), .checksum_i(cks_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .data_o(data_o[1]), .crc_err_o(crc_err_o[1]), .nak_o(nak_o[1]), .err_cnt_o(cnt1),
    .clr_cnt_i(clr_i[1]));

  urp_pcie_crc32_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .DROP_BAD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
    .data_i(data_i[2]), .checksum_i(cks_i[2]), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
    .data_o(data_o[2]), .crc_err_o(crc_err_o[2]), .nak_o(nak_o[2]), .err_cnt_o(cnt2),
    .clr_cnt_i(clr_i[2]));

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  int          cur = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          lat_chk = 0;
  bit          last_in_x = 0;
  int          n_out = 0;
  int          nak_cnt = 0;
  int          model_cnt [3];
  bit          drop_of [3];
  int          cnt_max [3];
  beat_t       exp_q [$];
  logic [31:0] tbl [256];
  bit          hold_prev = 0;
  logic [DW-1:0] prev_data;
  logic        prev_err;

  // Byte-at-a-time CRC32 (poly 0x04C11DB7, seed all-ones, MSB first, no final xor).
  function automatic logic [31:0] golden(input logic [DW-1:0] d);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = DW/8 - 1; i >= 0; i--) begin
      b = d[i*8 +: 8];
      c = (c << 8) ^ tbl[c[31:24] ^ b];
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // One clock: sample the selected instance 1 time unit after the falling edge
  // (the state that will be used at the next rising edge), update the
  // scoreboard, then advance to the next falling edge.
  task automatic step();
    logic  in_x;
    logic  out_x;
    beat_t e;
    logic  bad;
    #1;
    cyc++;
    in_x  = valid_i[cur] && ready_o[cur];
    out_x = valid_o[cur] && ready_i[cur];
    last_in_x = (in_x === 1'b1);
    if (mon_en) begin
      if (hold_prev) begin
        tests++;
        if (valid_o[cur] !== 1'b1 || data_o[cur] !== prev_data || crc_err_o[cur] !== prev_err) begin
          fails++;
          $display("[TB] FAIL stall_hold dut%0d: valid_o=%b err=%b, required held beat valid=1 err=%b",
                   cur, valid_o[cur], crc_err_o[cur], prev_err);
        end
      end
      if (nak_o[cur] === 1'b1) nak_cnt++;
      if (out_x === 1'b1) begin
        n_out++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL spurious_beat dut%0d: got data[31:0]=%h, required no beat", cur, data_o[cur][31:0]);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] out dut%0d cyc=%0d data[31:0]=%h crc_err=%b", cur, cyc, data_o[cur][31:0], crc_err_o[cur]);
          if (data_o[cur] !== e.data || crc_err_o[cur] !== e.err) begin
            fails++;
            $display("[TB] FAIL beat_order dut%0d: got data[31:0]=%h err=%b, required data[31:0]=%h err=%b",
                     cur, data_o[cur][31:0], crc_err_o[cur], e.data[31:0], e.err);
          end
          if (lat_chk) begin
            tests++;
            if (cyc - e.cyc != 2) begin
              fails++;
              $display("[TB] FAIL latency dut%0d: got %0d clk, required 2", cur, cyc - e.cyc);
            end
          end
        end
      end
      if (in_x === 1'b1) begin
        bad = (cks_i[cur] != golden(data_i[cur]));
        $display("[TB] in  dut%0d cyc=%0d data[31:0]=%h bad=%b", cur, cyc, data_i[cur][31:0], bad);
        if (bad && model_cnt[cur] < cnt_max[cur]) model_cnt[cur]++;
        if (!(drop_of[cur] && bad)) begin
          e.data = data_i[cur];
          e.err  = bad;
          e.cyc  = cyc;
          exp_q.push_back(e);
        end
      end
    end
    hold_prev = (valid_o[cur] === 1'b1) && (ready_i[cur] === 1'b0);
    prev_data = data_o[cur];
    prev_err  = crc_err_o[cur];
    @(negedge clk);
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic drive(input logic [DW-1:0] dat, input logic [31:0] ck);
    valid_i[cur] = 1'b1;
    data_i[cur]  = dat;
    cks_i[cur]   = ck;
    for (int k = 0; k < 64; k++) begin
      step();
      if (last_in_x) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL accept_timeout dut%0d: beat not accepted in 64 clk", cur);
  endtask

  task automatic drain();
    valid_i[cur] = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (exp_q.size() == 0 && valid_o[cur] !== 1'b1) break;
      step();
    end
    repeat (2) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain dut%0d: %0d beats still expected, required 0", cur, exp_q.size());
    end
  endtask

  task automatic select(input int d);
    cur = d;
    hold_prev = 0;
    n_out = 0;
    nak_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      valid_i[d] = 1'b0; ready_i[d] = 1'b1; clr_i[d] = 1'b0;
      data_i[d] = '0; cks_i[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (ready_o[d] !== 1'b0 || valid_o[d] !== 1'b0 || nak_o[d] !== 1'b0 || get_cnt(d) != 0) begin
        fails++;
        $display("[TB] FAIL reset_state dut%0d: ready=%b valid=%b nak=%b cnt=%0d, required 0 0 0 0",
                 d, ready_o[d], valid_o[d], nak_o[d], get_cnt(d));
      end
      model_cnt[d] = 0;
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (ready_o[d] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ready_after_reset dut%0d: got %b, required 1", d, ready_o[d]);
      end
    end
    @(negedge clk);
    mon_en = 1;
  endtask

  task automatic test_good_stream();
    logic [DW-1:0] d;
    select(0);
    lat_chk = 1;
    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      drive(d, golden(d));
    end
    drain();
    tests++;
    if (n_out != 8 || nak_cnt != 0 || get_cnt(0) != 0) begin
      fails++;
      $display("[TB] FAIL good_stream: out=%0d nak=%0d cnt=%0d, required 8 0 0", n_out, nak_cnt, get_cnt(0));
    end
  endtask

  task automatic run_bad3(input int d, input int want_out);
    logic [DW-1:0] v;
    logic [31:0]   ck;
    select(d);
    lat_chk = 1;
    for (int i = 1; i <= 5; i++) begin
      v  = rand_data();
      ck = golden(v);
      if (i == 3) ck = ck ^ 32'h1;
      drive(v, ck);
    end
    drain();
    tests++;
    if (n_out != want_out || nak_cnt != 1 || get_cnt(d) != model_cnt[d]) begin
      fails++;
      $display("[TB] FAIL bad_beat3 dut%0d: out=%0d nak=%0d cnt=%0d, required %0d 1 %0d",
               d, n_out, nak_cnt, get_cnt(d), want_out, model_cnt[d]);
    end
  endtask

  task automatic test_bad_forward();
    run_bad3(0, 5);
  endtask

  task automatic test_bad_drop();
    run_bad3(1, 4);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v;
    int acc;
    select(0);
    lat_chk = 0;
    ready_i[0] = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      v = rand_data();
      valid_i[0] = 1'b1;
      data_i[0]  = v;
      cks_i[0]   = golden(v);
      step();
      if (last_in_x) acc++;
    end
    tests++;
    if (acc != 2 || ready_o[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure: accepted=%0d ready_o=%b, required 2 0", acc, ready_o[0]);
    end
    valid_i[0] = 1'b0;
    ready_i[0] = 1'b1;
    drain();
    tests++;
    if (n_out != 2) begin
      fails++;
      $display("[TB] FAIL backpressure_release: out=%0d, required 2", n_out);
    end
  endtask

  task automatic test_saturate();
    logic [DW-1:0] v;
    int want;
    select(2);
    lat_chk = 1;
    for (int i = 0; i < 17; i++) begin
      v = rand_data();
      drive(v, ~golden(v));
    end
    drain();
    tests++;
    if (get_cnt(2) != 15 || model_cnt[2] != 15 || nak_cnt != 17) begin
      fails++;
      $display("[TB] FAIL saturate: cnt=%0d nak=%0d, required 15 17", get_cnt(2), nak_cnt);
    end
    // Bad beat reaching compare in the same cycle as a clear: 0 then +1.
    v = rand_data();
    drive(v, golden(v) ^ 32'h8000_0000);
    valid_i[2] = 1'b0;
    clr_i[2]   = 1'b1;
    step();
    clr_i[2]   = 1'b0;
    step();
    want = 0 + 1;
    tests++;
    if (get_cnt(2) != want) begin
      fails++;
      $display("[TB] FAIL clear_with_error: cnt=%0d, required %0d", get_cnt(2), want);
    end
    model_cnt[2] = want;
    drain();
    clr_i[2] = 1'b1;
    step();
    clr_i[2] = 1'b0;
    step();
    tests++;
    if (get_cnt(2) != 0) begin
      fails++;
      $display("[TB] FAIL clear_alone: cnt=%0d, required 0", get_cnt(2));
    end
    model_cnt[2] = 0;
  endtask

  task automatic test_reset_full();
    logic [DW-1:0] v;
    select(0);
    lat_chk = 0;
    ready_i[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v = rand_data();
      drive(v, golden(v));
    end
    step();
    tests++;
    if (ready_o[0] !== 1'b0 || valid_o[0] !== 1'b1 || cnt0 == 16'd0) begin
      fails++;
      $display("[TB] FAIL prefill: ready=%b valid=%b cnt=%0d, required 0 1 nonzero", ready_o[0], valid_o[0], cnt0);
    end
    mon_en = 0;
    valid_i[0] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    model_cnt[0] = 0;
    hold_prev = 0;
    #1;
    tests++;
    if (valid_o[0] !== 1'b0 || cnt0 !== 16'd0 || ready_o[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_full: valid=%b cnt=%0d ready=%b, required 0 0 1", valid_o[0], cnt0, ready_o[0]);
    end
    mon_en = 1;
    lat_chk = 1;
    ready_i[0] = 1'b1;
    n_out = 0;
    v = rand_data();
    drive(v, golden(v));
    drain();
    tests++;
    if (n_out != 1) begin
      fails++;
      $display("[TB] FAIL after_reset_beat: out=%0d, required 1", n_out);
    end
  endtask

  initial begin
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      tbl[i] = c;
    end
    drop_of = '{1'b0, 1'b1, 1'b0};
    cnt_max = '{65535, 65535, 15};
    test_reset();
    test_good_stream();
    test_bad_forward();
    test_bad_drop();
    test_backpressure();
    test_saturate();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
